alu_issue_stage: RTL and testbench

- Execute-stage front end of the pipelined CPU.
- Latches decoded instructions from ID and drives the `ALU` operand/opcode interface (`alu_a`, `alu_b`, `alu_op`); it receives `alu_c`/`alu_f` back.
- Resolves branches and jumps from `alu_f` and hands results to MEM through a registered valid/ready stage.
- Sits between ID and MEM; the combinational `ALU` hangs off its ALU ports.

---
 rtl/alu_issue_stage_if.sv | 58 +++++
 rtl/alu_issue_stage.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Bus between ID, the combinational ALU, MEM and the execute-stage front end.
// master = surrounding pipeline / ALU side, slave = alu_issue_stage.
interface alu_issue_stage_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_a_pc;
    logic        id_b_imm;
    logic [2:0]  id_br_type;
    logic        id_jalr;
    logic [4:0]  id_rd;
    logic        id_wb_en;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] mem_fwd_data;
    logic [31:0] wb_fwd_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_c;
    logic        alu_f;
    logic        ex_valid;
    logic        mem_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_alu_op,
        output id_a_pc, id_b_imm, id_br_type, id_jalr, id_rd, id_wb_en,
        input  id_ready,
        output fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
        input  alu_a, alu_b, alu_op,
        output alu_c, alu_f,
        input  ex_valid, ex_result, ex_store_data, ex_rd, ex_wb_en,
        output mem_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_alu_op,
        input  id_a_pc, id_b_imm, id_br_type, id_jalr, id_rd, id_wb_en,
        output id_ready,
        input  fwd_a_sel, fwd_b_sel, mem_fwd_data, wb_fwd_data,
        output alu_a, alu_b, alu_op,
        input  alu_c, alu_f,
        output ex_valid, ex_result, ex_store_data, ex_rd, ex_wb_en,
        input  mem_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: EX register feeding the ALU, branch resolution, OUT register to MEM.
// Optional feature macro: EX_FORWARD_EN (operand forwarding mux from MEM/WB).
module alu_issue_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    alu_issue_stage_if.slave  bus
);

    // Must match ALU_ADD in defines.vh.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [2:0] BR_BEQ   = 3'd1;
    localparam logic [2:0] BR_BNE   = 3'd2;
    localparam logic [2:0] BR_BLT   = 3'd3;
    localparam logic [2:0] BR_BGE   = 3'd4;
    localparam logic [2:0] BR_BLTU  = 3'd5;
    localparam logic [2:0] BR_BGEU  = 3'd6;
    localparam logic [2:0] BR_JUMP  = 3'd7;

    logic        v_ex;
    logic [31:0] pc_p0;
    logic [31:0] rs1_p0;
    logic [31:0] rs2_p0;
    logic [31:0] imm_p0;
    logic [3:0]  op_p0;
    logic        a_pc_p0;
    logic        b_imm_p0;
    logic [2:0]  br_p0;
    logic        jalr_p0;
    logic [4:0]  rd_p0;
    logic        wb_en_p0;

    logic        ex_valid_p1;
    logic [31:0] ex_result_p1;
    logic [31:0] ex_store_data_p1;
    logic [4:0]  ex_rd_p1;
    logic        ex_wb_en_p1;
    logic        redirect_valid_p1;
    logic [31:0] redirect_pc_p1;

    logic        out_free;
    logic        id_ready;
    logic        xfer;
    logic        taken;
    logic        flush;
    logic        load;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic [31:0] target;
    logic [31:0] result;
    logic [31:0] alu_a_c;
    logic [31:0] alu_b_c;
    logic [3:0]  alu_op_c;

    function automatic logic branch_taken(input logic [2:0] br, input logic f);
        case (br)
            BR_BEQ, BR_BLT, BR_BLTU: return f;
            BR_BNE, BR_BGE, BR_BGEU: return !f;
            BR_JUMP:                 return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
        case (sel)
            2'd1:    return mem_val;
            2'd2:    return wb_val;
            default: return reg_val;
        endcase
    endfunction

    assign out_free = !ex_valid_p1 || bus.mem_ready;
    assign id_ready = !v_ex || out_free;
    assign xfer     = v_ex && out_free;
    assign taken    = v_ex && branch_taken(br_p0, bus.alu_f);
    // Wrong-path instructions are accepted (handshake completes) but never enter EX.
    assign flush    = (xfer && taken) || redirect_valid_p1;
    assign load     = bus.id_valid && id_ready && !flush;

`ifdef EX_FORWARD_EN
    assign fwd_rs1 = fwd_mux(bus.fwd_a_sel, rs1_p0, bus.mem_fwd_data, bus.wb_fwd_data);
    assign fwd_rs2 = fwd_mux(bus.fwd_b_sel, rs2_p0, bus.mem_fwd_data, bus.wb_fwd_data);
`else
    logic unused_fwd;
    assign fwd_rs1    = rs1_p0;
    assign fwd_rs2    = rs2_p0;
    assign unused_fwd = ^{bus.fwd_a_sel, bus.fwd_b_sel, bus.mem_fwd_data, bus.wb_fwd_data};
`endif

    always_comb begin
        alu_a_c  = '0;
        alu_b_c  = '0;
        alu_op_c = ALU_ADD;
        if (v_ex) begin
            alu_a_c  = a_pc_p0 ? pc_p0 : fwd_rs1;
            alu_b_c  = b_imm_p0 ? imm_p0 : fwd_rs2;
            alu_op_c = op_p0;
        end
    end

    assign target = (br_p0 == BR_JUMP && jalr_p0) ? ((fwd_rs1 + imm_p0) & 32'hFFFF_FFFE)
                                                  : (pc_p0 + imm_p0);
    assign result = (br_p0 == BR_JUMP) ? (pc_p0 + 32'd4) : bus.alu_c;

    // ---- ID -> EX boundary (p0) ----
    always_ff @(posedge cpu_clk) begin
        if (load) begin
            pc_p0    <= bus.id_pc;
            rs1_p0   <= bus.id_rs1_data;
            rs2_p0   <= bus.id_rs2_data;
            imm_p0   <= bus.id_imm;
            op_p0    <= bus.id_alu_op;
            a_pc_p0  <= bus.id_a_pc;
            b_imm_p0 <= bus.id_b_imm;
            br_p0    <= bus.id_br_type;
            jalr_p0  <= bus.id_jalr;
            rd_p0    <= bus.id_rd;
            wb_en_p0 <= bus.id_wb_en;
        end
    end

    // ---- EX -> OUT boundary (p1) ----
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            v_ex              <= 1'b0;
            ex_valid_p1       <= 1'b0;
            ex_result_p1      <= '0;
            ex_store_data_p1  <= '0;
            ex_rd_p1          <= '0;
            ex_wb_en_p1       <= 1'b0;
            redirect_valid_p1 <= 1'b0;
            redirect_pc_p1    <= RESET_PC;
        end else begin
            redirect_valid_p1 <= xfer && taken;
            if (xfer && taken) begin
                redirect_pc_p1 <= target;
            end
            if (load) begin
                v_ex <= 1'b1;
            end else if (xfer) begin
                v_ex <= 1'b0;
            end
            if (xfer) begin
                ex_valid_p1      <= 1'b1;
                ex_result_p1     <= result;
                ex_store_data_p1 <= fwd_rs2;
                ex_rd_p1         <= rd_p0;
                ex_wb_en_p1      <= wb_en_p0;
            end else if (bus.mem_ready) begin
                ex_valid_p1 <= 1'b0;
            end
        end
    end

    assign bus.id_ready       = id_ready;
    assign bus.alu_a          = alu_a_c;
    assign bus.alu_b          = alu_b_c;
    assign bus.alu_op         = alu_op_c;
    assign bus.ex_valid       = ex_valid_p1;
    assign bus.ex_result      = ex_result_p1;
    assign bus.ex_store_data  = ex_store_data_p1;
    assign bus.ex_rd          = ex_rd_p1;
    assign bus.ex_wb_en       = ex_wb_en_p1;
    assign bus.redirect_valid = redirect_valid_p1;
    assign bus.redirect_pc    = redirect_pc_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic against a
// transaction-level model (in-order queue of results, redirect targets, wrong-path drops).
module tb_alu_issue_stage;

    localparam logic [31:0] RST_PC  = 32'h0000_1000;
    localparam logic [3:0]  OP_ADD  = 4'd0;
    localparam logic [3:0]  OP_SUB  = 4'd1;
    localparam logic [3:0]  OP_AND  = 4'd2;
    localparam logic [3:0]  OP_OR   = 4'd3;
    localparam logic [3:0]  OP_XOR  = 4'd4;
    localparam logic [3:0]  OP_SLL  = 4'd5;
    localparam logic [3:0]  OP_SRL  = 4'd6;
    localparam logic [3:0]  OP_SRA  = 4'd7;
    localparam logic [3:0]  OP_SLT  = 4'd8;
    localparam logic [3:0]  OP_SLTU = 4'd9;
`ifdef EX_FORWARD_EN
    localparam logic [31:0] FWD_A_EXP = 32'd10;
`else
    localparam logic [31:0] FWD_A_EXP = 32'd5;
`endif

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        wb;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_n = 0;
    int   last_taken = -100;
    exp_t exp_q[$];
    logic [31:0] red_q[$];

    always #5 clk = ~clk;

    alu_issue_stage_if bus();

    alu_issue_stage #(.RESET_PC(RST_PC)) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus.slave)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Flag: less-than for compares, zero otherwise.
    function automatic logic alu_flag(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        c = alu_fn(op, a, b);
        if (op == OP_SLT || op == OP_SLTU) return c[0];
        return c == 32'd0;
    endfunction

    always_comb begin
        bus.alu_c = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_f = alu_flag(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    // Reference: what an accepted instruction must produce, from architectural semantics.
    function automatic exp_t model_fn();
        exp_t e;
        logic [31:0] r1, r2, a, b;
        r1 = bus.id_rs1_data;
        r2 = bus.id_rs2_data;
`ifdef EX_FORWARD_EN
        if (bus.fwd_a_sel == 2'd1) r1 = bus.mem_fwd_data;
        else if (bus.fwd_a_sel == 2'd2) r1 = bus.wb_fwd_data;
        if (bus.fwd_b_sel == 2'd1) r2 = bus.mem_fwd_data;
        else if (bus.fwd_b_sel == 2'd2) r2 = bus.wb_fwd_data;
`endif
        a = bus.id_a_pc ? bus.id_pc : r1;
        b = bus.id_b_imm ? bus.id_imm : r2;
        e.result = (bus.id_br_type == 3'd7) ? bus.id_pc + 32'd4 : alu_fn(bus.id_alu_op, a, b);
        e.store  = r2;
        e.rd     = bus.id_rd;
        e.wb     = bus.id_wb_en;
        case (bus.id_br_type)
            3'd1:    e.taken = (r1 == r2);
            3'd2:    e.taken = (r1 != r2);
            3'd3:    e.taken = ($signed(r1) < $signed(r2));
            3'd4:    e.taken = ($signed(r1) >= $signed(r2));
            3'd5:    e.taken = (r1 < r2);
            3'd6:    e.taken = (r1 >= r2);
            3'd7:    e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
        e.target = (bus.id_br_type == 3'd7 && bus.id_jalr) ? ((r1 + bus.id_imm) & 32'hFFFF_FFFE)
                                                           : (bus.id_pc + bus.id_imm);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        cyc_n++;
        if (!rst && bus.ex_valid && bus.mem_ready) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL out_extra: observed output rd=%0d result=%h, expected none", bus.ex_rd, bus.ex_result);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ex_result", bus.ex_result, e.result);
                chk("ex_store_data", bus.ex_store_data, e.store);
                chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
                chk("ex_wb_en", 32'(bus.ex_wb_en), 32'(e.wb));
            end
        end
        if (bus.redirect_valid) begin
            n_checks++;
            assert (red_q.size() > 0) else begin
                n_fail++;
                $error("FAIL redirect_extra: observed redirect to %h, expected none", bus.redirect_pc);
            end
            if (red_q.size() > 0) chk("redirect_pc", bus.redirect_pc, red_q.pop_front());
        end
        // With MEM ready, a taken instruction accepted at edge k kills accepts at k+1 and k+2.
        if (!rst && bus.id_valid && bus.id_ready) begin
            e = model_fn();
            if (cyc_n - last_taken > 2) begin
                exp_q.push_back(e);
                if (e.taken) begin
                    red_q.push_back(e.target);
                    last_taken = cyc_n;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [3:0] op, input logic a_pc,
                          input logic b_imm, input logic [2:0] br, input logic jalr,
                          input logic [4:0] rd, input logic wb);
        bus.id_pc       = pc;
        bus.id_rs1_data = rs1;
        bus.id_rs2_data = rs2;
        bus.id_imm      = imm;
        bus.id_alu_op   = op;
        bus.id_a_pc     = a_pc;
        bus.id_b_imm    = b_imm;
        bus.id_br_type  = br;
        bus.id_jalr     = jalr;
        bus.id_rd       = rd;
        bus.id_wb_en    = wb;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic set_fwd(input logic [1:0] sa, input logic [1:0] sb, input logic [31:0] m, input logic [31:0] w);
        bus.fwd_a_sel    = sa;
        bus.fwd_b_sel    = sb;
        bus.mem_fwd_data = m;
        bus.wb_fwd_data  = w;
    endtask

    task automatic drain();
        bus.id_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        logic [31:0] tmp;
        logic [2:0]  br;
        logic [3:0]  op;

        bus.id_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        set_id(0, 0, 0, 0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0);
        set_fwd(2'd0, 2'd0, 32'd0, 32'd0);

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, RST_PC);
        chk("rst_ex_result", bus.ex_result, 32'd0);
        chk("rst_ex_store_data", bus.ex_store_data, 32'd0);
        chk("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
        chk("rst_ex_wb_en", 32'(bus.ex_wb_en), 32'd0);
        chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
        chk("idle_alu_a", bus.alu_a, 32'd0);
        chk("idle_alu_b", bus.alu_b, 32'd0);
        chk("idle_alu_op", 32'(bus.alu_op), 32'(OP_ADD));

        // Forwarded ADD
        set_fwd(2'd1, 2'd0, 32'd10, 32'd99);
        set_id(32'h10, 32'd5, 32'd7, 32'd0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd3, 1'b1);
        bus.id_valid = 1'b1;
        step();
        bus.id_valid = 1'b0;
        chk("fwd_alu_a", bus.alu_a, FWD_A_EXP);
        chk("fwd_alu_b", bus.alu_b, 32'd7);
        chk("fwd_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        step();
        chk("fwd_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("fwd_ex_result", bus.ex_result, FWD_A_EXP + 32'd7);
        step();
        chk("fwd_ex_valid_clear", 32'(bus.ex_valid), 32'd0);
        set_fwd(2'd0, 2'd0, 32'd0, 32'd0);

        // Taken BEQ: two following ID instructions are dropped
        set_id(32'h100, 32'd3, 32'd3, 32'h20, OP_SUB, 1'b0, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        bus.id_valid = 1'b1;
        step();
        set_id(32'h104, 32'd1, 32'd1, 32'd0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd5, 1'b1);
        step();
        chk("beq_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("beq_redirect_pc", bus.redirect_pc, 32'h120);
        chk("beq_id_ready_in_redirect", 32'(bus.id_ready), 32'd1);
        set_id(32'h108, 32'd2, 32'd2, 32'd0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd6, 1'b1);
        step();
        chk("beq_redirect_once", 32'(bus.redirect_valid), 32'd0);
        chk("beq_drop1_ex_valid", 32'(bus.ex_valid), 32'd0);
        set_id(32'h120, 32'd40, 32'd2, 32'd0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd7, 1'b1);
        step();
        bus.id_valid = 1'b0;
        chk("beq_drop2_ex_valid", 32'(bus.ex_valid), 32'd0);
        step();
        chk("beq_target_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("beq_target_ex_result", bus.ex_result, 32'd42);
        step();

        // Not-taken BLTU (0xFFFFFFFF <u 1 is false)
        set_id(32'h140, 32'hFFFF_FFFF, 32'd1, 32'h40, OP_SLTU, 1'b0, 1'b0, 3'd5, 1'b0, 5'd0, 1'b0);
        bus.id_valid = 1'b1;
        step();
        bus.id_valid = 1'b0;
        step();
        chk("bltu_no_redirect", 32'(bus.redirect_valid), 32'd0);
        step();
        chk("bltu_no_redirect2", 32'(bus.redirect_valid), 32'd0);

        // JALR
        set_id(32'h200, 32'h1001, 32'd0, 32'd4, OP_ADD, 1'b0, 1'b1, 3'd7, 1'b1, 5'd1, 1'b1);
        bus.id_valid = 1'b1;
        step();
        bus.id_valid = 1'b0;
        step();
        chk("jalr_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("jalr_redirect_pc", bus.redirect_pc, 32'h1004);
        chk("jalr_ex_result", bus.ex_result, 32'h204);
        step();
        chk("jalr_redirect_once", 32'(bus.redirect_valid), 32'd0);
        step();

        // Backpressure with EX and OUT full
        bus.mem_ready = 1'b0;
        set_id(32'h300, 32'd1, 32'd2, 32'd0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd4, 1'b1);
        bus.id_valid = 1'b1;
        step();
        set_id(32'h304, 32'h11, 32'h22, 32'd0, OP_XOR, 1'b0, 1'b0, 3'd0, 1'b0, 5'd5, 1'b1);
        step();
        set_id(32'h308, 32'h100, 32'h200, 32'd0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_id_ready", 32'(bus.id_ready), 32'd0);
            chk("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
            chk("bp_ex_result", bus.ex_result, 32'd3);
            chk("bp_alu_a", bus.alu_a, 32'h11);
            chk("bp_alu_b", bus.alu_b, 32'h22);
            chk("bp_alu_op", 32'(bus.alu_op), 32'(OP_XOR));
            if (i < 3) step();
        end
        bus.mem_ready = 1'b1;
        step();
        bus.id_valid = 1'b0;
        chk("bp_drain_ex_result", bus.ex_result, 32'h33);
        repeat (3) step();
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random traffic, no branches, random backpressure
        set_fwd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom(), $urandom());
        for (int i = 0; i < 400; i++) begin
            bus.id_valid  = ($urandom_range(0, 99) < 70);
            bus.mem_ready = ($urandom_range(0, 99) < 65);
            set_id($urandom(), pick_val(), pick_val(), $urandom(), 4'($urandom_range(0, 9)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd0, 1'b0,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            step();
        end
        drain();

        // Random branches and jumps, MEM always ready
        set_fwd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick_val(), pick_val());
        for (int i = 0; i < 400; i++) begin
            bus.id_valid  = ($urandom_range(0, 99) < 75);
            bus.mem_ready = 1'b1;
            tmp = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) < 4) begin
                set_id(tmp, pick_val(), pick_val(), $urandom(), 4'($urandom_range(0, 9)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd0, 1'b0,
                       5'($urandom_range(0, 31)), 1'b1);
            end else begin
                br = 3'($urandom_range(1, 7));
                case (br)
                    3'd1, 3'd2: op = OP_SUB;
                    3'd3, 3'd4: op = OP_SLT;
                    3'd5, 3'd6: op = OP_SLTU;
                    default:    op = OP_ADD;
                endcase
                set_id(tmp, pick_val(), pick_val(), $urandom(), op, 1'b0, 1'b0, br,
                       (br == 3'd7) ? 1'($urandom_range(0, 1)) : 1'b0,
                       5'($urandom_range(0, 31)), br == 3'd7);
            end
            step();
        end
        drain();
        set_fwd(2'd0, 2'd0, 32'd0, 32'd0);

        // Reset while a taken branch is stalled in EX
        bus.mem_ready = 1'b0;
        set_id(32'h400, 32'd8, 32'd9, 32'd0, OP_ADD, 1'b0, 1'b0, 3'd0, 1'b0, 5'd9, 1'b1);
        bus.id_valid = 1'b1;
        step();
        set_id(32'h404, 32'd9, 32'd9, 32'd8, OP_SUB, 1'b0, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        step();
        bus.id_valid = 1'b0;
        repeat (2) begin
            step();
            chk("stall_no_redirect", 32'(bus.redirect_valid), 32'd0);
            chk("stall_id_ready", 32'(bus.id_ready), 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        red_q.delete();
        last_taken = -100;
        chk("mid_rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("mid_rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("mid_rst_redirect_pc", bus.redirect_pc, RST_PC);
        chk("mid_rst_id_ready", 32'(bus.id_ready), 32'd1);
        chk("mid_rst_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        bus.mem_ready = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_no_redirect", 32'(bus.redirect_valid), 32'd0);
            chk("post_rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        end

        chk("final_out_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_redirect_queue_empty", 32'(red_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
